// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encodings and timing defaults for button blocks
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } btn_state_t;

    // Defaults shared with the debouncer so both ends of the chain agree on timing
    localparam int DEB_COUNT_MAX      = 16;
    localparam int LONG_PRESS_DEFAULT = 16;
    localparam int REPEAT_DEFAULT     = 4;
    localparam int COUNT_W_DEFAULT    = 8;

endpackage

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - debounced level in, event strobes and status out
interface button_event_decoder_if #(
    parameter int COUNT_W = 8
);
    logic               button_in;
    logic               press_pulse;
    logic               release_pulse;
    logic               long_pulse;
    logic               repeat_pulse;
    logic               held;
    logic [COUNT_W-1:0] press_count;

    modport master (
        output button_in,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );

    modport slave (
        input  button_in,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );
endinterface

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - registers the previous level and flags rising/falling edges
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic prev_in;

    // prev_in clears on reset so a level already high afterwards reads as a rise
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_in <= 1'b0;
        end else begin
            prev_in <= level;
        end
    end

    assign rise = level & ~prev_in;
    assign fall = ~level & prev_in;
endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - press/release/long/repeat strobes from a debounced level
// Optional auto-repeat enabled by defining BTN_AUTOREPEAT_EN.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
    parameter int REPEAT_CYCLES     = REPEAT_DEFAULT,
    parameter int COUNT_W           = COUNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    button_event_decoder_if.slave bus
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    btn_state_t         state;
    logic [HW-1:0]      hold_cnt;
    logic [COUNT_W-1:0] count_q;
    logic               press_q, release_q, long_q, held_q;
    logic               rise, fall;
    logic               long_hit;

    btn_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.button_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign long_hit = (state == ST_PRESSED) && !fall && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        press_q  <= 1'b1;
                        held_q   <= 1'b1;
                        count_q  <= count_q + COUNT_W'(1);
                        hold_cnt <= HW'(1);
                        state    <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end else if (long_hit) begin
                        long_q   <= 1'b1;
                        hold_cnt <= HOLD_MAX;
                        state    <= ST_LONG;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_LONG: begin
                    // hold_cnt stays frozen at the threshold until release
                    if (fall) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    held_q   <= 1'b0;
                    hold_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          repeat_q;

    // A release on the repeat edge suppresses the strobe because fall gates the LONG branch
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt  <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            if (long_hit) begin
                rep_cnt <= '0;
            end else if (state == ST_LONG && !fall) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt  <= '0;
                    repeat_q <= 1'b1;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end
    end

    assign bus.repeat_pulse = repeat_q;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
    assign bus.repeat_pulse  = 1'b0;
`endif

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.held          = held_q;
    assign bus.press_count   = count_q;
endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench comparing all outputs against a run-length model
module tb_button_event_decoder;
    localparam int L = 16;
    localparam int R = 4;
    localparam int W = 8;

    typedef struct packed {
        logic         press;
        logic         rel;
        logic         lng;
        logic         rep;
        logic         held;
        logic [W-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;

    button_event_decoder_if #(.COUNT_W(W)) bus ();

    button_event_decoder #(
        .LONG_PRESS_CYCLES (L),
        .REPEAT_CYCLES     (R),
        .COUNT_W           (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Model state: previous sample, in-press flag, consecutive high run since the press edge
    bit           m_prev;
    bit           m_in;
    int           m_run;
    logic [W-1:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit b);
        exp_t e;
        exp_t got;
        reset         = r;
        bus.button_in = b;
        e = '0;
        if (!r) begin
            m_prev = 1'b0;
            m_in   = 1'b0;
            m_run  = 0;
            m_cnt  = '0;
        end else begin
            if (b && !m_prev) begin
                e.press = 1'b1;
                m_in    = 1'b1;
                m_run   = 1;
                m_cnt   = m_cnt + 1'b1;
            end else if (b && m_in) begin
                m_run++;
                if (m_run == L) e.lng = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                if (m_run > L && ((m_run - L) % R) == 0) e.rep = 1'b1;
`endif
            end else if (!b && m_prev && m_in) begin
                e.rel = 1'b1;
                m_in  = 1'b0;
                m_run = 0;
            end
            m_prev = b;
        end
        e.held = m_in;
        e.cnt  = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse,
               bus.held, bus.press_count};
        e = exp_q.pop_front();
        check_eq("outputs", 32'(got), 32'(e));
        check_eq("onehot", 32'($countones({got.press, got.rel, got.lng, got.rep}) <= 1), 32'd1);
    endtask

    task automatic press_for(input int high, input int low);
        for (int i = 0; i < high; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < low; i++)  cycle(1'b1, 1'b0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.button_in = 1'b0;
        m_prev = 1'b0;
        m_in   = 1'b0;
        m_run  = 0;
        m_cnt  = '0;

        // Button high through reset: press on the first edge after release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        press_for(4, 3);

        press_for(5, 3);      // short press, no long
        press_for(15, 3);     // release lands on the long threshold edge
        press_for(16, 3);     // long fires on the final high sample
        press_for(30, 3);     // long plus repeats
        press_for(40, 3);
        press_for(1, 3);      // single-cycle glitch

        for (int n = 0; n < 256; n++) press_for(1, 1);

        // Reset mid-LONG with the button still held
        press_for(20, 0);
        cycle(1'b0, 1'b1);
        press_for(3, 2);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
